// File: rtl/fp_special_pack.sv
// Purpose: packs class/sign/extended-exponent/mantissa into an IEEE-style word; optional macro FP_SPECIAL_PACK_SUBNORMAL_EN.
// Latency: 2 cycles (S1 classify, S2 pack) at 1 word/cycle throughput.
// Backpressure: valid/ready both sides; stalled stages hold, in_ready = !s1_valid | s2_load.
module fp_special_pack #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_class,
    input  logic                 in_sign,
    input  logic [EXP_W+1:0]     in_exp,
    input  logic [DATA_W-EXP_W-1:0] in_man,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int MAN_W = DATA_W - EXP_W;
    localparam int XE_W  = EXP_W + 2;

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    localparam logic signed [XE_W-1:0] EXP_MAX   = XE_W'((1 << EXP_W) - 1);
    localparam logic signed [XE_W-1:0] EXP_ZERO  = '0;
    localparam logic [EXP_W-1:0]       EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]       EXP_NONE  = '0;
    localparam logic [MAN_W-2:0]       FRAC_ZERO = '0;
    localparam logic [MAN_W-2:0]       FRAC_QNAN = {1'b1, {(MAN_W-2){1'b0}}};

`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
    // Hidden bit is kept so the denormalising shift can bring it into the fraction.
    localparam int KEEP_W = MAN_W;
    localparam int SH_W   = $clog2(MAN_W + 1);
    localparam logic signed [XE_W:0] SH_SAT = (XE_W+1)'(MAN_W);
`else
    localparam int KEEP_W = MAN_W - 1;
    // Hidden bit is never needed when underflow flushes to zero.
    logic unused_hidden;
    assign unused_hidden = in_man[MAN_W-1];
`endif

    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_class_q, s1_class_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic [KEEP_W-1:0] s1_man_q,   s1_man_d;
    logic              s1_ovf_q,   s1_ovf_d;
    logic              s1_unf_q,   s1_unf_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_dat_q,   s2_dat_d;
    logic              s2_ovf_q,   s2_ovf_d;
    logic              s2_unf_q,   s2_unf_d;

    logic              s1_load, s2_load;
    logic              in_ovf, in_unf;
    logic [DATA_W-1:0] pack_dat;
    logic              pack_ovf, pack_unf;

`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
    logic [SH_W-1:0]   s1_shift_q, s1_shift_d;
    logic signed [XE_W:0] shift_full;
    logic [MAN_W-1:0]  sub_man;
    logic              unused_sub_msb;
    assign unused_sub_msb = sub_man[MAN_W-1];
`endif

    // Handshake: each stage advances when empty or when its contents move on.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = s1_load;
    end

    // S1 classification: range flags only apply to normal-class words.
    always_comb begin
        in_ovf = (in_class == CLS_NORM) && ($signed(in_exp) >= EXP_MAX);
        in_unf = (in_class == CLS_NORM) && ($signed(in_exp) <= EXP_ZERO);
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
        shift_full = $signed({{XE_W{1'b0}}, 1'b1}) - $signed({in_exp[XE_W-1], in_exp});
        if (!in_unf) begin
            s1_shift_d = '0;
        end else if (shift_full >= SH_SAT) begin
            s1_shift_d = SH_W'(MAN_W);
        end else begin
            s1_shift_d = shift_full[SH_W-1:0];
        end
        if (!s1_load || !in_valid) begin
            s1_shift_d = s1_shift_q;
        end
`endif
    end

    // S2 packing: first matching case wins; NaN is always the canonical quiet NaN.
    always_comb begin
        pack_dat = '0;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
        sub_man  = s1_man_q >> s1_shift_q;
`endif
        case (s1_class_q)
            CLS_NAN:  pack_dat = {1'b0, EXP_ONES, FRAC_QNAN};
            CLS_INF:  pack_dat = {s1_sign_q, EXP_ONES, FRAC_ZERO};
            CLS_ZERO: pack_dat = {s1_sign_q, EXP_NONE, FRAC_ZERO};
            default: begin
                if (s1_ovf_q) begin
                    pack_dat = {s1_sign_q, EXP_ONES, FRAC_ZERO};
                    pack_ovf = 1'b1;
                end else if (s1_unf_q) begin
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
                    pack_dat = {s1_sign_q, EXP_NONE, sub_man[MAN_W-2:0]};
`else
                    pack_dat = {s1_sign_q, EXP_NONE, FRAC_ZERO};
`endif
                    pack_unf = 1'b1;
                end else begin
                    pack_dat = {s1_sign_q, s1_exp_q, s1_man_q[MAN_W-2:0]};
                end
            end
        endcase
    end

    // Next-state for both stages; stalled stages keep their contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_class_d = s1_class_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_ovf_d   = s1_ovf_q;
        s1_unf_d   = s1_unf_q;
        s2_valid_d = s2_valid_q;
        s2_dat_d   = s2_dat_q;
        s2_ovf_d   = s2_ovf_q;
        s2_unf_d   = s2_unf_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_class_d = in_class;
                s1_sign_d  = in_sign;
                s1_exp_d   = in_exp[EXP_W-1:0];
                s1_man_d   = in_man[KEEP_W-1:0];
                s1_ovf_d   = in_ovf;
                s1_unf_d   = in_unf;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_dat_d = pack_dat;
                s2_ovf_d = pack_ovf;
                s2_unf_d = pack_unf;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_class_q <= '0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s1_unf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_dat_q   <= '0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
            s1_shift_q <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_class_q <= s1_class_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_q   <= s1_man_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_unf_q   <= s1_unf_d;
            s2_valid_q <= s2_valid_d;
            s2_dat_q   <= s2_dat_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_unf_q   <= s2_unf_d;
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
            s1_shift_q <= s1_shift_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign data_out  = s2_dat_q;
    assign overflow  = s2_ovf_q && s2_valid_q;
    assign underflow = s2_unf_q && s2_valid_q;
endmodule

// File: tb/tb_fp_special_pack.sv
// Directed and random checks of the float packer against hand-computed values and a small model.
// Clock period 10; inputs driven and outputs sampled 1 time unit after the rising edge.
// A run ends with a single summary line.
module tb_fp_special_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_class;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [23:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
        logic        u;
    } exp_t;

    fp_special_pack #(.DATA_W(32), .EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] c, input logic s,
                          input logic [9:0] e, input logic [23:0] m);
        in_valid = v;
        in_class = c;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    // Sends one word into an idle pipe and captures the first output word.
    task automatic push_and_wait(input logic [1:0] c, input logic s, input logic [9:0] e,
                                 input logic [23:0] m, output logic got, output logic [31:0] d,
                                 output logic o, output logic u, output int lat);
        got = 1'b0; d = '0; o = 1'b0; u = 1'b0; lat = 0;
        out_ready = 1'b1;
        set_in(1'b1, c, s, e, m);
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (out_valid) begin
                got = 1'b1; d = data_out; o = overflow; u = underflow; lat = k + 1;
                break;
            end
        end
    endtask

    // Behavioural reference used for the random stream.
    function automatic void ref_model(input logic [1:0] c, input logic s, input logic [9:0] e,
                                      input logic [23:0] m, output logic [31:0] d,
                                      output logic o, output logic u);
        int ei;
        int sh;
        logic [23:0] t;
        ei = int'($signed(e));
        o = 1'b0; u = 1'b0; d = '0; sh = 0; t = '0;
        if (c == 2'b11) d = 32'h7FC00000;
        else if (c == 2'b10) d = {s, 8'hFF, 23'd0};
        else if (c == 2'b01) d = {s, 31'd0};
        else if (ei >= 255) begin d = {s, 8'hFF, 23'd0}; o = 1'b1; end
        else if (ei <= 0) begin
            u = 1'b1;
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
            sh = 1 - ei;
            if (sh >= 24) d = {s, 31'd0};
            else begin t = m >> sh; d = {s, 8'd0, t[22:0]}; end
`else
            d = {s, 31'd0};
`endif
        end
        else d = {s, e[7:0], m[22:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 10'd0, 24'd0);
        out_ready = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset data_out got %h want 00000000", data_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow got %b want 0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset underflow got %b want 0", underflow); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_normal();
        logic got; logic [31:0] d; logic o, u; int lat;
        drain();
        push_and_wait(2'b00, 1'b0, 10'd127, 24'h800000, got, d, o, u, lat);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL normal timeout got %b want 1", got); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL normal latency got %0d want 2", lat); end
        n_checks++; if (d !== 32'h3F800000) begin n_fail++; $display("FAIL normal data got %h want 3f800000", d); end
        n_checks++; if ({o, u} !== 2'b00) begin n_fail++; $display("FAIL normal flags got %b want 00", {o, u}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  cls [3] = '{2'b11, 2'b01, 2'b10};
        logic        sgn [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] want[3] = '{32'h7FC00000, 32'h80000000, 32'h7F800000};
        drain();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1'b1, cls[i], sgn[i], 10'd77, 24'hABCDEF);
            else in_valid = 1'b0;
            cycle();
            if (i >= 1 && i <= 3) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b valid[%0d] got %b want 1", i-1, out_valid); end
                n_checks++; if (data_out !== want[i-1]) begin n_fail++; $display("FAIL b2b data[%0d] got %h want %h", i-1, data_out, want[i-1]); end
            end
            if (i == 4) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b extra word valid got %b want 0", out_valid); end
            end
        end
    endtask

    task automatic test_ovf_unf();
        logic [1:0]  cls [13] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                  2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        logic        sgn [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0]  ex  [13] = '{10'd255, 10'h3FD, 10'd0, 10'h3E2, 10'd1, 10'd254, 10'h1FF,
                                  10'h200, 10'd0, 10'd0, 10'h12C, 10'h3FF, 10'd256};
        logic [23:0] mn  [13] = '{24'hC00000, 24'h800000, 24'h800000, 24'hFFFFFF, 24'hFFFFFF,
                                  24'h800001, 24'h800000, 24'h800000, 24'h123456, 24'h000000,
                                  24'hFFFFFF, 24'hC00000, 24'h800000};
`ifdef FP_SPECIAL_PACK_SUBNORMAL_EN
        logic [31:0] wd  [13] = '{32'hFF800000, 32'h00080000, 32'h00400000, 32'h00000000,
                                  32'h80FFFFFF, 32'h7F000001, 32'h7F800000, 32'h80000000,
                                  32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80300000,
                                  32'h7F800000};
`else
        logic [31:0] wd  [13] = '{32'hFF800000, 32'h00000000, 32'h00000000, 32'h00000000,
                                  32'h80FFFFFF, 32'h7F000001, 32'h7F800000, 32'h80000000,
                                  32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000,
                                  32'h7F800000};
`endif
        logic        wo  [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        wu  [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic got; logic [31:0] d; logic o, u; int lat;
        for (int i = 0; i < 13; i++) begin
            drain();
            push_and_wait(cls[i], sgn[i], ex[i], mn[i], got, d, o, u, lat);
            n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL range[%0d] timeout got %b want 1", i, got); end
            n_checks++; if (d !== wd[i]) begin n_fail++; $display("FAIL range[%0d] data got %h want %h", i, d, wd[i]); end
            n_checks++; if (o !== wo[i]) begin n_fail++; $display("FAIL range[%0d] overflow got %b want %b", i, o, wo[i]); end
            n_checks++; if (u !== wu[i]) begin n_fail++; $display("FAIL range[%0d] underflow got %b want %b", i, u, wu[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic        sg[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0]  ex[4] = '{10'd100, 10'd110, 10'd120, 10'd130};
        logic [23:0] mn[4] = '{24'h800000, 24'h811111, 24'h822222, 24'h833333};
        logic [31:0] wd[4] = '{32'h32000000, 32'hB7011111, 32'h3C022222, 32'hC1033333};
        int accepted = 0;
        int outs = 0;
        logic fire;
        drain();
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            if (accepted < 4) set_in(1'b1, 2'b00, sg[accepted], ex[accepted], mn[accepted]);
            else in_valid = 1'b0;
            #1;
            if (c >= 2 && c <= 4) begin
                n_checks++; if (in_ready !== 1'b0 || accepted != 2) begin n_fail++; $display("FAIL bp stall c%0d in_ready got %b accepted %0d want 0 and 2", c, in_ready, accepted); end
                n_checks++; if (out_valid !== 1'b1 || data_out !== wd[0]) begin n_fail++; $display("FAIL bp hold c%0d got v=%b %h want v=1 %h", c, out_valid, data_out, wd[0]); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (outs >= 4) begin n_fail++; $display("FAIL bp duplicate word got %h want none", data_out); end
                else if (data_out !== wd[outs]) begin n_fail++; $display("FAIL bp order[%0d] got %h want %h", outs, data_out, wd[outs]); end
                outs++;
            end
            fire = in_valid && in_ready;
            cycle();
            if (fire) accepted++;
        end
        n_checks++; if (outs != 4) begin n_fail++; $display("FAIL bp drained count got %0d want 4", outs); end
    endtask

    task automatic test_reset_midstream();
        logic got; logic [31:0] d; logic o, u; int lat;
        drain();
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, 1'b1, 10'd300, 24'h800000);
        cycle();
        set_in(1'b1, 2'b00, 1'b0, 10'd10, 24'h800000);
        cycle();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
        n_checks++; if (data_out !== 32'hFF800000 || overflow !== 1'b1) begin n_fail++; $display("FAIL midrst pre word got %h ovf=%b want ff800000 ovf=1", data_out, overflow); end
        rst = 1'b1;
        cycle();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL midrst data_out got %h want 00000000", data_out); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL midrst flags got %b want 00", {overflow, underflow}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        cycle();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst after got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        push_and_wait(2'b00, 1'b0, 10'd127, 24'h800000, got, d, o, u, lat);
        n_checks++; if (got !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL midrst new word got=%b lat=%0d want got=1 lat=2", got, lat); end
        n_checks++; if (d !== 32'h3F800000) begin n_fail++; $display("FAIL midrst new data got %h want 3f800000", d); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic fire;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] md; logic mo, mu;
        drain();
        while (recv < 10000 && cyc < 60000) begin
            if (sent < 10000 && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                in_class = 2'($urandom_range(0, 3));
                in_sign  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) in_exp = 10'($urandom_range(0, 260));
                else in_exp = 10'($urandom_range(0, 1023));
                in_man = 24'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (stalled) begin
                n_checks++; if (out_valid !== 1'b1 || data_out !== held) begin n_fail++; $display("FAIL rand stable got v=%b %h want v=1 %h", out_valid, data_out, held); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand spurious word got %h want none", data_out);
                end else begin
                    e = q.pop_front();
                    if ({data_out, overflow, underflow} !== {e.d, e.o, e.u}) begin
                        n_fail++;
                        $display("FAIL rand word %0d got %h o=%b u=%b want %h o=%b u=%b", recv, data_out, overflow, underflow, e.d, e.o, e.u);
                    end
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            held = data_out;
            fire = in_valid && in_ready;
            if (fire) begin
                ref_model(in_class, in_sign, in_exp, in_man, md, mo, mu);
                q.push_back('{d: md, o: mo, u: mu});
                sent++;
            end
            cycle();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (recv != 10000) begin n_fail++; $display("FAIL rand received got %0d want 10000", recv); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_ovf_unf();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
